// File: rtl/adder_pkg.sv
// adder_pkg: state encodings, switch codes and display constants
// shared by the adder sequencing controller and its switch filter.
`default_nettype none

package adder_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'b000,
    ST_LOAD_B  = 3'b001,
    ST_ADD_REQ = 3'b010,
    ST_SHOW    = 3'b011,
    ST_ERR     = 3'b100
  } state_t;

  localparam logic [1:0] SW_LOAD_A = 2'b00;
  localparam logic [1:0] SW_LOAD_B = 2'b01;
  localparam logic [1:0] SW_ADD    = 2'b11;
  localparam logic [1:0] SW_BAD    = 2'b10;

  localparam logic [3:0] DISP_ERR  = 4'hF;

endpackage : adder_pkg

`default_nettype wire

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchronizer for the mode switches, followed by a
// stability filter when ADDER_SEQ_DEBOUNCE_EN is defined (pass-through otherwise).
`default_nettype none

module sw_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_i,
  output logic [1:0] sw_o
);

  logic [1:0] meta_q;
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= sw_i;
      sync_q <= meta_q;
    end
  end

`ifdef ADDER_SEQ_DEBOUNCE_EN
  localparam logic [15:0] CNT_LAST = 16'(DB_CYCLES - 1);

  logic [1:0]  filt_q, filt_d;
  logic [1:0]  cand_q, cand_d;
  logic [15:0] cnt_q, cnt_d;

  // cnt_q counts cycles the candidate value has been seen unchanged.
  always_comb begin
    filt_d = filt_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync_q == filt_q) begin
      cand_d = sync_q;
      cnt_d  = 16'd0;
    end else if (sync_q != cand_q) begin
      cand_d = sync_q;
      cnt_d  = 16'd1;
      if (CNT_LAST == 16'd0) begin
        filt_d = sync_q;
        cnt_d  = 16'd0;
      end
    end else if (cnt_q >= CNT_LAST) begin
      filt_d = sync_q;
      cnt_d  = 16'd0;
    end else begin
      cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 2'b00;
      cand_q <= 2'b00;
      cnt_q  <= 16'd0;
    end else begin
      filt_q <= filt_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sw_o = filt_q;
`else
  logic unused_db;
  assign unused_db = ^16'(DB_CYCLES);
  assign sw_o      = sync_q;
`endif

endmodule : sw_debounce

`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: operand entry / add handshake / display sequencer for the
// 4-bit adder board. Switch filtering depends on ADDER_SEQ_DEBOUNCE_EN.
`default_nettype none

module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter int DB_CYCLES  = 16,
  parameter int TMO_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw,
  input  logic [3:0] tgl,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       start,
  input  logic       done,
  input  logic [4:0] sum,
  output logic [4:0] result,
  output logic [3:0] disp,
  output logic [2:0] state,
  output logic       err
);

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES);

  logic [1:0]  sw_q;
  state_t      state_q, state_d;
  logic [3:0]  op_a_q, op_a_d;
  logic [3:0]  op_b_q, op_b_d;
  logic [4:0]  result_q, result_d;
  logic [15:0] tmo_q, tmo_d;

  sw_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_sw_debounce (
    .clk   (clk),
    .reset (reset),
    .sw_i  (sw),
    .sw_o  (sw_q)
  );

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    tmo_d    = 16'd0;
    case (state_q)
      ST_LOAD_A: begin
        op_a_d = tgl;
        case (sw_q)
          SW_LOAD_B: state_d = ST_LOAD_B;
          SW_BAD:    state_d = ST_ERR;
          default:   state_d = ST_LOAD_A;
        endcase
      end
      ST_LOAD_B: begin
        op_b_d = tgl;
        case (sw_q)
          SW_ADD:    state_d = ST_ADD_REQ;
          SW_LOAD_A: state_d = ST_LOAD_A;
          SW_BAD:    state_d = ST_ERR;
          default:   state_d = ST_LOAD_B;
        endcase
      end
      ST_ADD_REQ: begin
        // done wins over abort, abort wins over timeout
        if (done) begin
          result_d = sum;
          state_d  = ST_SHOW;
        end else if (sw_q == SW_LOAD_A) begin
          state_d  = ST_LOAD_A;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = ST_ERR;
        end else begin
          tmo_d    = tmo_q + 16'd1;
        end
      end
      ST_SHOW, ST_ERR: begin
        if (sw_q == SW_LOAD_A) begin
          state_d  = ST_LOAD_A;
          op_a_d   = 4'd0;
          op_b_d   = 4'd0;
          result_d = 5'd0;
        end
      end
      default: state_d = ST_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOAD_A;
      op_a_q   <= 4'd0;
      op_b_q   <= 4'd0;
      result_q <= 5'd0;
      tmo_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      tmo_q    <= tmo_d;
    end
  end

  // All visible outputs decode registered state only.
  always_comb begin
    case (state_q)
      ST_LOAD_A:             disp = op_a_q;
      ST_LOAD_B, ST_ADD_REQ: disp = op_b_q;
      ST_SHOW:               disp = result_q[3:0];
      ST_ERR:                disp = DISP_ERR;
      default:               disp = 4'd0;
    endcase
  end

  assign start  = (state_q == ST_ADD_REQ);
  assign err    = (state_q == ST_ERR);
  assign state  = state_q;
  assign op_a   = op_a_q;
  assign op_b   = op_b_q;
  assign result = result_q;

endmodule : adder_seq_ctrl

`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: randomized transaction bench; the bench plays the adder
// datapath and predicts results, handshake lengths and state from the rules.
`default_nettype none

module tb_adder_seq_ctrl;

  localparam int DB  = 4;
  localparam int TMO = 8;
  localparam logic [2:0] S_LA = 3'b000, S_LB = 3'b001, S_AR = 3'b010,
                         S_SH = 3'b011, S_ER = 3'b100;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sw;
  logic [3:0] tgl;
  logic [3:0] op_a, op_b;
  logic       start;
  logic       done;
  logic [4:0] sum;
  logic [4:0] result;
  logic [3:0] disp;
  logic [2:0] state;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  adder_seq_ctrl #(.DB_CYCLES(DB), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .sw(sw), .tgl(tgl), .op_a(op_a), .op_b(op_b),
    .start(start), .done(done), .sum(sum), .result(result), .disp(disp),
    .state(state), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] exp, input string tag);
    int n = 0;
    while (state !== exp && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(state), 32'(exp));
  endtask

  task automatic back_to_load_a(input string tag);
    sw = 2'b00;
    wait_state(S_LA, {tag, "_to_la"});
    check({tag, "_clr_a"}, 32'(op_a), 32'd0);
    check({tag, "_clr_b"}, 32'(op_b), 32'd0);
    check({tag, "_clr_res"}, 32'(result), 32'd0);
    check({tag, "_err_lo"}, 32'(err), 32'd0);
  endtask

  task automatic enter_add(input logic [3:0] a, input logic [3:0] b, input string tag);
    tgl = a;
    sw  = 2'b01;
    wait_state(S_LB, {tag, "_lb"});
    check({tag, "_op_a"}, 32'(op_a), 32'(a));
    tgl = b;
    sw  = 2'b11;
  endtask

  // delay = number of start-high cycles before done is driven high
  task automatic do_add(input logic [3:0] a, input logic [3:0] b, input int delay, input string tag);
    logic [4:0] exp_sum;
    int starts = 0;
    int k = 0;
    exp_sum = 5'(a) + 5'(b);
    enter_add(a, b, tag);
    if (delay == 0) begin
      done = 1'b1;
      sum  = exp_sum;
    end
    wait_state(S_AR, {tag, "_ar"});
    while (state === S_AR && k < 50) begin
      if (k == delay) begin
        done = 1'b1;
        sum  = exp_sum;
      end
      if (start) starts++;
      tick();
      k++;
    end
    done = 1'b0;
    check({tag, "_start_len"}, 32'(starts), 32'(delay + 1));
    check({tag, "_start_lo"}, 32'(start), 32'd0);
    check({tag, "_show"}, 32'(state), 32'(S_SH));
    check({tag, "_result"}, 32'(result), 32'(exp_sum));
    check({tag, "_disp"}, 32'(disp), 32'(exp_sum[3:0]));
    check({tag, "_op_b"}, 32'(op_b), 32'(b));
    back_to_load_a(tag);
  endtask

  initial begin
    int starts;
    int seen_lb;
    int left_la;
    logic [3:0] ra, rb;

    reset = 1'b1; sw = 2'b00; tgl = 4'd0; done = 1'b0; sum = 5'd0;
    #23;
    check("rst_state", 32'(state), 32'(S_LA));
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_op_b", 32'(op_b), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_disp", 32'(disp), 32'd0);
    reset = 1'b0;
    tick();

    do_add(4'd9, 4'd7, 2, "normal");
    do_add(4'd8, 4'd7, 0, "immediate");
    do_add(4'd15, 4'd15, 1, "max");
    for (int i = 0; i < 5; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      do_add(ra, rb, int'($urandom_range(0, 6)), $sformatf("rand%0d", i));
    end

    // timeout: done never arrives
    enter_add(4'd3, 4'd4, "tmo");
    wait_state(S_AR, "tmo_ar");
    starts = 0;
    for (int k = 0; k < 40 && state === S_AR; k++) begin
      if (start) starts++;
      tick();
    end
    check("tmo_len", 32'(starts), 32'(TMO + 1));
    check("tmo_state", 32'(state), 32'(S_ER));
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_disp", 32'(disp), 32'hF);
    check("tmo_result", 32'(result), 32'd0);
    back_to_load_a("tmo");

    // illegal code from LOAD_A
    sw = 2'b10;
    wait_state(S_ER, "bad_err");
    check("bad_err_hi", 32'(err), 32'd1);
    back_to_load_a("bad");

    // 11 in LOAD_A must not skip ahead
    sw = 2'b11;
    left_la = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (state !== S_LA) left_la++;
    end
    check("skip_stay", 32'(left_la), 32'd0);
    sw = 2'b00;
    repeat (DB + 6) tick();

    // bounce 00<->01 every 2 cycles
    seen_lb = 0;
    for (int k = 0; k < 20; k++) begin
      sw = (k % 4 < 2) ? 2'b01 : 2'b00;
      tick();
      if (state === S_LB) seen_lb++;
    end
`ifdef ADDER_SEQ_DEBOUNCE_EN
    check("bounce_filtered", 32'(seen_lb), 32'd0);
`else
    check("bounce_follows", 32'(seen_lb > 0), 32'd1);
`endif
    sw = 2'b01;
    wait_state(S_LB, "bounce_settle");
    sw = 2'b00;
    wait_state(S_LA, "bounce_back");

    // asynchronous reset in the middle of a handshake
    enter_add(4'd5, 4'd6, "rmid");
    wait_state(S_AR, "rmid_ar");
    tick(); tick();
    check("rmid_start_hi", 32'(start), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rmid_start", 32'(start), 32'd0);
    check("rmid_state", 32'(state), 32'(S_LA));
    check("rmid_op_a", 32'(op_a), 32'd0);
    check("rmid_op_b", 32'(op_b), 32'd0);
    check("rmid_result", 32'(result), 32'd0);
    sw = 2'b00;
    tick(); tick();
    reset = 1'b0;
    tick();
    do_add(4'd1, 4'd2, 1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adder_seq_ctrl

`default_nettype wire
